mem_bus_fabric: RTL and testbench
=================================

Name: mem_bus_fabric

Overview:
- Parametrised memory-mapped interconnect between a picorv32-style native memory master and up to NUM_SLAVES slaves.
- Replaces hand-written chip-select, ready and read-mux logic at top level.
- Decodes a region index from the address and drives per-slave select and write-strobe.
- Generates a registered mem_ready. Per slave, completion is either fixed-latency or slave-handshake.
- Adds a timeout watchdog and unmapped-address error reporting.

Parameters:
NUM_SLAVES, 8, number of slave ports; region indices >= NUM_SLAVES are unmapped
SEL_LSB, 12, lowest address bit of the region index
SEL_BITS, 4, width of the region index
SLAVE_LAT, {8{4'd1}}, 4 bits per slave (slave i at [4i+3:4i]); 0 = handshake mode (wait for slv_ready), 1..15 = fixed wait cycles
TIMEOUT, 255, maximum handshake wait cycles before forced error completion
TIMEOUT_W, 8, counter width (must hold TIMEOUT)
ERR_DATA, 32'hDEADBEEF, read data returned on error completion

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
mem_valid  in  1  master request valid; held until mem_ready
mem_addr  in  32  master address; stable while mem_valid
mem_wdata  in  32  master write data
mem_wstrb  in  4  byte write strobes; 0 = read
mem_ready  out  1  one-cycle completion pulse, registered
mem_rdata  out  32  registered read data; valid when mem_ready=1
slv_sel  out  NUM_SLAVES  one-hot select, high throughout BUSY
slv_start  out  NUM_SLAVES  one-cycle pulse on first BUSY cycle, selected slave only
slv_wstrb  out  4  mem_wstrb during the first BUSY cycle only, else 0
slv_wdata  out  32  mem_wdata pass-through
slv_ready  in  NUM_SLAVES  per-slave done (handshake mode only; ignored in fixed mode)
slv_rdata  in  32*NUM_SLAVES  flattened read data, slave i at [32i+31:32i]
err  out  1  sticky error flag
err_addr  out  32  address of the most recent errored access
err_clr  in  1  clears err

Behaviour:
- Reset: when rst_n=0 at a clk edge, state←IDLE.
  - mem_ready, mem_rdata, slv_sel, slv_start, err and err_addr all ←0.
  - An in-flight transaction is abandoned. No mem_ready is issued for it.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If mem_valid=1, latch idx=mem_addr[SEL_LSB+SEL_BITS-1:SEL_LSB].
  - If idx<NUM_SLAVES: cnt←SLAVE_LAT[idx] (fixed mode) or cnt←0 (handshake mode), then →BUSY.
  - If idx>=NUM_SLAVES (unmapped): mem_rdata←ERR_DATA, err←1, err_addr←mem_addr, →RESP. No slave is selected; writes are dropped.
- BUSY, fixed mode:
  - cnt decrements each cycle.
  - In the cycle where cnt==1, capture mem_rdata←slv_rdata[idx], then →RESP.
  - mem_ready is therefore high exactly L+1 cycles after the first IDLE cycle that sees mem_valid (L=SLAVE_LAT[idx]).
- BUSY, handshake mode:
  - cnt increments each cycle.
  - If slv_ready[idx]=1 in a cycle (including the first BUSY cycle), capture mem_rdata←slv_rdata[idx], then →RESP.
  - Otherwise, if cnt==TIMEOUT-1: mem_rdata←ERR_DATA, err←1, err_addr←mem_addr, →RESP.
  - If slv_ready and the timeout condition occur in the same cycle, slv_ready wins.
- RESP:
  - mem_ready=1 for exactly this cycle. slv_sel=0.
  - mem_valid is ignored in RESP. Next state is always IDLE.
  - A back-to-back request is accepted at the earliest in the cycle after RESP.
- slv_start and nonzero slv_wstrb occur exactly once per transaction, so side-effecting slaves (e.g. UART transmit) fire once.
- mem_rdata holds its value between transactions. Writes also update mem_rdata with the captured slave data (don't-care for the master).
- err_clr:
  - clears err in the following cycle.
  - If err_clr and a new error coincide, the set wins and err_addr updates.
- A counter reaching its wrap point must not overflow: TIMEOUT ≤ 2^TIMEOUT_W-1.

Test Plan:
- Read, slave 0 (L=1, slv_rdata[31:0]=32'h12345678) at addr 0x0000_0004: mem_valid cycle 0 → slv_sel=8'h01 in cycle 1, mem_ready=1 in cycle 2 only, mem_rdata=32'h12345678.
- Write, slave 3 with SLAVE_LAT[15:12]=3, wstrb=4'hF, addr 0x3000 → slv_wstrb=4'hF and slv_start[3]=1 in cycle 1 only; mem_ready in cycle 4.
- Handshake read, slave 4 (lat 0), slv_ready[4] asserted in the 5th BUSY cycle with data 32'hCAFEF00D → mem_ready the next cycle, mem_rdata=32'hCAFEF00D, err=0.
- Handshake timeout: slave 4, slv_ready never asserted, TIMEOUT=16 → mem_ready in cycle 17, mem_rdata=32'hDEADBEEF, err=1, err_addr=0x4000. Pulse err_clr → err=0 next cycle.
- Unmapped access to 0x9000 (NUM_SLAVES=8) → mem_ready in cycle 1, mem_rdata=32'hDEADBEEF, slv_sel stays 0, err=1.
- Two back-to-back reads to slaves 0 and 1 with mem_valid held high → exactly two mem_ready pulses separated by RESP→IDLE. Then rst_n=0 mid-BUSY → mem_ready never asserts, all outputs 0 the next cycle.

Source files
------------

// File: rtl/mem_bus_fabric.sv
// mem_bus_fabric
//   Memory-mapped interconnect between one picorv32-style native memory master
//   and up to NUM_SLAVES slaves. Decodes a region index from the address and
//   drives a registered one-hot slave select. It also drives a single-cycle
//   start pulse and write strobe toward the slave.
//   A transaction completes in one of three ways:
//     - after a fixed number of wait cycles (fixed mode);
//     - when the slave raises slv_ready (handshake mode);
//     - when a handshake times out or the address is unmapped. These error
//       completions return ERR_DATA and set the sticky err flag.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   mem_valid/addr/wdata/wstrb   master request (wstrb==0 means read)
//   mem_ready, mem_rdata         registered completion pulse and read data
//   slv_sel           one-hot select, high while the transaction is BUSY
//   slv_start         one-cycle pulse on the first BUSY cycle
//   slv_wstrb         write strobes, first BUSY cycle only
//   slv_wdata         write data pass-through
//   slv_ready         per-slave done (handshake-mode slaves only)
//   slv_rdata         flattened slave read data, slave i at [32i+31:32i]
//   err, err_addr     sticky error flag and address of the latest errored access
//   err_clr           clears err (a coincident new error wins)
module mem_bus_fabric #(
   parameter int                        NUM_SLAVES = 8,
   parameter int                        SEL_LSB    = 12,
   parameter int                        SEL_BITS   = 4,
   parameter logic [4*NUM_SLAVES-1:0]   SLAVE_LAT  = {NUM_SLAVES{4'd1}},
   parameter int                        TIMEOUT    = 255,
   parameter int                        TIMEOUT_W  = 8,
   parameter logic [31:0]               ERR_DATA   = 32'hDEADBEEF
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         mem_valid,
   input  logic [31:0]                  mem_addr,
   input  logic [31:0]                  mem_wdata,
   input  logic [3:0]                   mem_wstrb,
   output logic                         mem_ready,
   output logic [31:0]                  mem_rdata,
   output logic [NUM_SLAVES-1:0]        slv_sel,
   output logic [NUM_SLAVES-1:0]        slv_start,
   output logic [3:0]                   slv_wstrb,
   output logic [31:0]                  slv_wdata,
   input  logic [NUM_SLAVES-1:0]        slv_ready,
   input  logic [32*NUM_SLAVES-1:0]     slv_rdata,
   output logic                         err,
   output logic [31:0]                  err_addr,
   input  logic                         err_clr
);

   localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam logic [NUM_SLAVES-1:0][3:0] LAT_ARR = SLAVE_LAT;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t                       state;
   logic [IDX_W-1:0]             slot;    // latched slave index of the transaction
   logic                         hs;      // latched: slave completes by handshake
   logic [TIMEOUT_W-1:0]         cnt;

   logic [SEL_BITS-1:0]          dec_idx;
   logic [IDX_W-1:0]             dec_slot;
   logic                         dec_mapped;
   logic                         dec_hs;
   logic [NUM_SLAVES-1:0]        dec_oh;
   logic [NUM_SLAVES-1:0][31:0]  rdata_arr;

   assign rdata_arr  = slv_rdata;
   assign slv_wdata  = mem_wdata;

   assign dec_idx    = mem_addr[SEL_LSB+SEL_BITS-1:SEL_LSB];
   assign dec_slot   = dec_idx[IDX_W-1:0];
   assign dec_mapped = (32'(dec_idx) < NUM_SLAVES);
   // Only meaningful when dec_mapped; unmapped indices never reach BUSY.
   assign dec_hs     = (LAT_ARR[dec_slot] == 4'd0);

   for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_dec
      assign dec_oh[i] = dec_mapped && (dec_slot == IDX_W'(i));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         slot      <= '0;
         hs        <= 1'b0;
         cnt       <= '0;
         mem_ready <= 1'b0;
         mem_rdata <= '0;
         slv_sel   <= '0;
         slv_start <= '0;
         slv_wstrb <= '0;
         err       <= 1'b0;
         err_addr  <= '0;
      end else begin
         // Pulses default low; any error set below overrides err_clr.
         mem_ready <= 1'b0;
         slv_start <= '0;
         slv_wstrb <= '0;
         if (err_clr) err <= 1'b0;

         unique case (state)
            IDLE: begin
               if (mem_valid) begin
                  if (dec_mapped) begin
                     slot      <= dec_slot;
                     hs        <= dec_hs;
                     cnt       <= dec_hs ? '0 : TIMEOUT_W'(LAT_ARR[dec_slot]);
                     slv_sel   <= dec_oh;
                     slv_start <= dec_oh;
                     slv_wstrb <= mem_wstrb;
                     state     <= BUSY;
                  end else begin
                     // Unmapped: no slave sees the access, writes are dropped.
                     mem_rdata <= ERR_DATA;
                     err       <= 1'b1;
                     err_addr  <= mem_addr;
                     mem_ready <= 1'b1;
                     state     <= RESP;
                  end
               end
            end
            BUSY: begin
               if (hs) begin
                  cnt <= cnt + 1'b1;
                  if (slv_ready[slot]) begin
                     mem_rdata <= rdata_arr[slot];
                     mem_ready <= 1'b1;
                     slv_sel   <= '0;
                     state     <= RESP;
                  end else if (cnt == TIMEOUT_W'(TIMEOUT - 1)) begin
                     mem_rdata <= ERR_DATA;
                     err       <= 1'b1;
                     err_addr  <= mem_addr;
                     mem_ready <= 1'b1;
                     slv_sel   <= '0;
                     state     <= RESP;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
                  if (cnt == TIMEOUT_W'(1)) begin
                     mem_rdata <= rdata_arr[slot];
                     mem_ready <= 1'b1;
                     slv_sel   <= '0;
                     state     <= RESP;
                  end
               end
            end
            RESP: begin
               // mem_valid may still be high for the finished request; ignore it.
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_fabric.sv
module tb_mem_bus_fabric;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic [7:0]  slv_sel;
   logic [7:0]  slv_start;
   logic [3:0]  slv_wstrb;
   logic [31:0] slv_wdata;
   logic [7:0]  slv_ready;
   logic [255:0] slv_rdata;
   logic        err;
   logic [31:0] err_addr;
   logic        err_clr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Slave 3: 3 wait cycles, slave 4: handshake, all others: 1 wait cycle.
   mem_bus_fabric #(
      .NUM_SLAVES(8), .SEL_LSB(12), .SEL_BITS(4),
      .SLAVE_LAT(32'h1110_3111), .TIMEOUT(16), .TIMEOUT_W(8),
      .ERR_DATA(32'hDEADBEEF)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .slv_sel(slv_sel), .slv_start(slv_start), .slv_wstrb(slv_wstrb), .slv_wdata(slv_wdata),
      .slv_ready(slv_ready), .slv_rdata(slv_rdata),
      .err(err), .err_addr(err_addr), .err_clr(err_clr)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      int          rdy_at;   // BUSY cycle in which slv_ready[4] is raised, 0 = never
      int          lat;      // cycle of mem_ready counted from the request cycle
      logic [31:0] rdata;
      logic        err;
      logic [7:0]  sel;
      logic [3:0]  ws;       // strobes expected on slv_wstrb (once)
   } vec_t;

   // One transaction starting in an IDLE cycle; observes outputs each cycle
   // until mem_ready or the cycle budget runs out.
   task automatic run_txn(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd,
                          input int rdy_at,
                          output int lat, output logic [31:0] rd, output logic er,
                          output logic [31:0] ea, output logic [7:0] sel_or,
                          output logic [7:0] st_or, output int st_n,
                          output logic [3:0] ws_or, output int ws_n);
      lat = -1; rd = '0; er = 1'b0; ea = '0; sel_or = '0; st_or = '0; st_n = 0; ws_or = '0; ws_n = 0;
      @(negedge clk);
      mem_addr = a; mem_wstrb = ws; mem_wdata = wd; mem_valid = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); @(negedge clk);
         sel_or |= slv_sel;
         st_or  |= slv_start;
         if (slv_start != 0) st_n++;
         ws_or  |= slv_wstrb;
         if (slv_wstrb != 0) ws_n++;
         if (mem_ready) begin
            lat = k; rd = mem_rdata; er = err; ea = err_addr;
            break;
         end
         slv_ready = (k == rdy_at) ? 8'h10 : 8'h00;
      end
      mem_valid = 1'b0; mem_wstrb = '0; slv_ready = '0;
   endtask

   initial begin
      vec_t        vecs[10];
      int          lat, st_n, ws_n, n, p1, p2;
      logic [31:0] rd, ea;
      logic        er;
      logic [7:0]  sel_or, st_or;
      logic [3:0]  ws_or;
      string       tag;

      vecs[0] = '{32'h0000_0004, 4'h0, 32'h0,         0,  2, 32'h12345678, 1'b0, 8'h01, 4'h0};
      vecs[1] = '{32'h0000_3000, 4'hF, 32'hAABBCCDD,  0,  4, 32'h33333333, 1'b0, 8'h08, 4'hF};
      vecs[2] = '{32'h0000_4000, 4'h0, 32'h0,         5,  6, 32'hCAFEF00D, 1'b0, 8'h10, 4'h0};
      vecs[3] = '{32'h0000_4000, 4'h0, 32'h0,         0, 17, 32'hDEADBEEF, 1'b1, 8'h10, 4'h0};
      vecs[4] = '{32'h0000_9000, 4'h0, 32'h0,         0,  1, 32'hDEADBEEF, 1'b1, 8'h00, 4'h0};
      vecs[5] = '{32'h0000_4010, 4'h0, 32'h0,         1,  2, 32'hCAFEF00D, 1'b0, 8'h10, 4'h0};
      vecs[6] = '{32'h0000_4020, 4'h0, 32'h0,        16, 17, 32'hCAFEF00D, 1'b0, 8'h10, 4'h0};
      vecs[7] = '{32'h0000_7ABC, 4'h0, 32'h0,         0,  2, 32'h77777777, 1'b0, 8'h80, 4'h0};
      vecs[8] = '{32'h0000_F000, 4'h3, 32'h01020304,  0,  1, 32'hDEADBEEF, 1'b1, 8'h00, 4'h0};
      vecs[9] = '{32'h0000_2008, 4'h5, 32'h0,         0,  2, 32'h22222222, 1'b0, 8'h04, 4'h5};

      slv_rdata = {32'h77777777, 32'h66666666, 32'h55555555, 32'hCAFEF00D,
                   32'h33333333, 32'h22222222, 32'h11111111, 32'h12345678};
      rst_n = 1'b0; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
      slv_ready = '0; err_clr = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_ready", 32'(mem_ready), 32'd0);
      chk("rst_mem_rdata", mem_rdata, 32'd0);
      chk("rst_slv_sel",   32'(slv_sel), 32'd0);
      chk("rst_slv_start", 32'(slv_start), 32'd0);
      chk("rst_err",       32'(err), 32'd0);
      chk("rst_err_addr",  err_addr, 32'd0);
      rst_n = 1'b1;

      for (int v = 0; v < 10; v++) begin
         run_txn(vecs[v].addr, vecs[v].wstrb, vecs[v].wdata, vecs[v].rdy_at,
                 lat, rd, er, ea, sel_or, st_or, st_n, ws_or, ws_n);
         tag = $sformatf("v%0d_", v);
         chk({tag, "latency"}, 32'(lat), 32'(vecs[v].lat));
         chk({tag, "rdata"},   rd, vecs[v].rdata);
         chk({tag, "err"},     32'(er), 32'(vecs[v].err));
         chk({tag, "sel"},     32'(sel_or), 32'(vecs[v].sel));
         chk({tag, "start"},   32'(st_or), 32'(vecs[v].sel));
         chk({tag, "start_n"}, 32'(st_n), (vecs[v].sel != 0) ? 32'd1 : 32'd0);
         chk({tag, "wstrb"},   32'(ws_or), 32'(vecs[v].ws));
         chk({tag, "wstrb_n"}, 32'(ws_n), (vecs[v].ws != 0) ? 32'd1 : 32'd0);
         if (vecs[v].err) begin
            chk({tag, "err_addr"}, ea, vecs[v].addr);
            err_clr = 1'b1;
            @(negedge clk);
            err_clr = 1'b0;
            chk({tag, "err_cleared"}, 32'(err), 32'd0);
         end
         @(negedge clk);
         chk({tag, "ready_pulse"}, 32'(mem_ready), 32'd0);
      end

      // Back-to-back reads with mem_valid held: RESP, IDLE, BUSY, RESP.
      @(negedge clk);
      mem_addr = 32'h0000_0000; mem_wstrb = '0; mem_valid = 1'b1;
      n = 0; p1 = -1; p2 = -1; rd = '0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); @(negedge clk);
         if (mem_ready) begin
            n++;
            if (n == 1) begin
               p1 = k; mem_addr = 32'h0000_1000;
            end else begin
               p2 = k; rd = mem_rdata; mem_valid = 1'b0;
            end
         end
      end
      mem_valid = 1'b0;
      chk("b2b_count",  32'(n), 32'd2);
      chk("b2b_first",  32'(p1), 32'd2);
      chk("b2b_second", 32'(p2), 32'd5);
      chk("b2b_rdata",  rd, 32'h11111111);

      // Unmapped access with err_clr held: the new error wins.
      @(negedge clk);
      mem_addr = 32'h0000_A000; mem_valid = 1'b1; err_clr = 1'b1;
      @(posedge clk); @(negedge clk);
      mem_valid = 1'b0;
      chk("clrset_ready",    32'(mem_ready), 32'd1);
      chk("clrset_err",      32'(err), 32'd1);
      chk("clrset_err_addr", err_addr, 32'h0000_A000);
      @(negedge clk);
      err_clr = 1'b0;
      chk("clrset_cleared",  32'(err), 32'd0);

      // Reset in the middle of a 3-cycle access to slave 3.
      @(negedge clk);
      mem_addr = 32'h0000_3000; mem_wstrb = '0; mem_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("midrst_busy_sel", 32'(slv_sel), 32'h08);
      @(posedge clk); @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("midrst_mem_ready", 32'(mem_ready), 32'd0);
      chk("midrst_mem_rdata", mem_rdata, 32'd0);
      chk("midrst_slv_sel",   32'(slv_sel), 32'd0);
      chk("midrst_slv_start", 32'(slv_start), 32'd0);
      chk("midrst_err_addr",  err_addr, 32'd0);
      rst_n = 1'b1; mem_valid = 1'b0;
      n = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); @(negedge clk);
         if (mem_ready) n++;
      end
      chk("midrst_no_ready", 32'(n), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
